// File: rtl/transpose_pp.sv
// Ping-pong N x N bit-matrix transposer.
// Rows stream into one bank while the other bank streams out as columns.
// Only control state is reset; bank contents are never cleared.
module transpose_pp #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] data_i,
  input  logic         valid_i,
  output logic         ready_o,
  output logic [N-1:0] data_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic         last_o
);

  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [N-1:0]  mem_q [2][N];
  logic [N-1:0]  mem_d [2][N];
  logic          wr_sel_q, wr_sel_d;
  logic          rd_sel_q, rd_sel_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [1:0]    full_q, full_d;

  logic wr_fire;
  logic rd_fire;

  // Handshake flags; both are forced low while reset is asserted.
  always_comb begin
    ready_o = !rst && !full_q[wr_sel_q];
    valid_o = !rst && full_q[rd_sel_q];
    wr_fire = valid_i && ready_o;
    rd_fire = valid_o && ready_i;
  end

  // Next-state for counters, bank selects and full flags. A write and a
  // read can never target the same bank in one cycle (write needs the
  // bank empty, read needs it full), so both full-flag updates may apply.
  always_comb begin
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    full_d   = full_q;
    if (wr_fire) begin
      if (wr_cnt_q == LAST) begin
        wr_cnt_d         = '0;
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = !wr_sel_q;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end
    if (rd_fire) begin
      if (rd_cnt_q == LAST) begin
        rd_cnt_d         = '0;
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = !rd_sel_q;
      end else begin
        rd_cnt_d = rd_cnt_q + 1'b1;
      end
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      full_q   <= '0;
    end else begin
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      full_q   <= full_d;
    end
  end

  // Bank write: accepted row lands in row wr_cnt of the write bank.
  always_comb begin
    mem_d = mem_q;
    if (wr_fire) begin
      mem_d[wr_sel_q][wr_cnt_q] = data_i;
    end
  end

  // Bank storage, intentionally not reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Column read: bit k of the output is bit rd_cnt of row k.
  always_comb begin
    data_o = '0;
    if (valid_o) begin
      for (int k = 0; k < N; k++) begin
        data_o[k] = mem_q[rd_sel_q][k][rd_cnt_q];
      end
    end
    last_o = valid_o && (rd_cnt_q == LAST);
  end

endmodule

// File: tb/tb_transpose_pp.sv
// Directed + random bench for transpose_pp at N=4 with a scoreboard queue.
module tb_transpose_pp;

  localparam int N = 4;

  typedef struct packed {
    logic [N-1:0] data;
    logic         last;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [N-1:0] data_i;
  logic         valid_i;
  logic         ready_o;
  logic [N-1:0] data_o;
  logic         valid_o;
  logic         ready_i;
  logic         last_o;

  int total = 0;
  int bad   = 0;

  exp_t         exp_q[$];
  logic [N-1:0] rows [N];
  int           wr_n = 0;

  transpose_pp #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .last_o  (last_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Scoreboard monitor: collects accepted rows, pushes the transposed
  // frame, and checks every output cycle against the queue head.
  always @(negedge clk) begin
    exp_t e;
    exp_t c;
    if (rst) begin
      exp_q.delete();
      wr_n = 0;
    end else begin
      if (valid_o) begin
        total++;
        assert (exp_q.size() > 0)
        else begin
          bad++;
          $error("FAIL sb_underflow obs_data=%h exp=none", data_o);
        end
        if (exp_q.size() > 0) begin
          e = exp_q[0];
          total++;
          assert (data_o === e.data)
          else begin
            bad++;
            $error("FAIL sb_data obs=%h exp=%h", data_o, e.data);
          end
          total++;
          assert (last_o === e.last)
          else begin
            bad++;
            $error("FAIL sb_last obs=%b exp=%b", last_o, e.last);
          end
          if (ready_i) void'(exp_q.pop_front());
        end
      end else begin
        total++;
        assert (data_o === '0 && last_o === 1'b0)
        else begin
          bad++;
          $error("FAIL idle_outputs obs=%h/%b exp=0/0", data_o, last_o);
        end
      end
      if (valid_i && ready_o) begin
        rows[wr_n] = data_i;
        wr_n++;
        if (wr_n == N) begin
          for (int j = 0; j < N; j++) begin
            for (int k = 0; k < N; k++) c.data[k] = rows[k][j];
            c.last = (j == N - 1);
            exp_q.push_back(c);
          end
          wr_n = 0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one word and hold it until accepted (bounded).
  task automatic send(input logic [N-1:0] w);
    logic got;
    got     = 1'b0;
    data_i  = w;
    valid_i = 1'b1;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      got = ready_o;
      @(posedge clk);
      #1;
    end
    valid_i = 1'b0;
    chk("send_accept", {7'd0, got}, 8'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {7'd0, ready_o}, 8'd1);
    chk({tag, "_valid"}, {7'd0, valid_o}, 8'd0);
    chk({tag, "_data"},  {4'd0, data_o},  8'd0);
    chk({tag, "_last"},  {7'd0, last_o},  8'd0);
  endtask

  initial begin
    int acc;
    int cyc;
    rst     = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    data_i  = '0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_ready_low", {7'd0, ready_o}, 8'd0);
    chk("rst_valid_low", {7'd0, valid_o}, 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("post_reset");
    @(posedge clk);
    #1;

    // Identity matrix, with first-output latency check.
    send(4'h1);
    send(4'h2);
    send(4'h4);
    send(4'h8);
    @(negedge clk);
    chk("ident_latency_valid", {7'd0, valid_o}, 8'd1);
    chk("ident_c0", {4'd0, data_o}, 8'h01);
    @(posedge clk);
    #1;
    idle(6);

    // Single-row patterns.
    send(4'hF); send(4'h0); send(4'h0); send(4'h0);
    idle(6);
    send(4'h0); send(4'h0); send(4'h0); send(4'hF);
    idle(6);

    // Backpressure: two frames fill both banks.
    ready_i = 1'b0;
    send(4'h3); send(4'h5); send(4'h9); send(4'h6);
    send(4'hA); send(4'hC); send(4'h7); send(4'hE);
    data_i  = 4'hF;
    valid_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_both_full_ready", {7'd0, ready_o}, 8'd0);
      @(posedge clk);
      #1;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("bp_draining_ready", {7'd0, ready_o}, 8'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("bp_ready_back", {7'd0, ready_o}, 8'd1);
    @(posedge clk);
    #1;
    idle(6);

    // Streaming: three frames back-to-back, continuous output.
    ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      data_i  = N'((i * 5 + 3) % 16);
      valid_i = 1'b1;
      @(negedge clk);
      chk("stream_ready", {7'd0, ready_o}, 8'd1);
      chk("stream_valid", {7'd0, valid_o}, {7'd0, i >= 4});
      @(posedge clk);
      #1;
    end
    valid_i = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("stream_tail_valid", {7'd0, valid_o}, {7'd0, j < 4});
      @(posedge clk);
      #1;
    end

    // Random gaps on both sides, 100 frames.
    acc = 0;
    cyc = 0;
    while (acc < 100 * N && cyc < 20000) begin
      valid_i = ($urandom_range(0, 9) < 7);
      data_i  = N'($urandom);
      ready_i = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (valid_i && ready_o) acc++;
      @(posedge clk);
      #1;
      cyc++;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    chk("rand_accepted_all", {7'd0, acc == 100 * N}, 8'd1);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 200) begin
      idle(1);
      cyc++;
    end
    chk("rand_drained", 8'(exp_q.size()), 8'd0);

    // Reset mid-operation: frame 1 half read, frame 2 half written.
    ready_i = 1'b0;
    send(4'h1); send(4'h2); send(4'h3); send(4'h4);
    ready_i = 1'b1;
    idle(2);
    ready_i = 1'b0;
    send(4'h5); send(4'h6);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("mid_reset");
    @(posedge clk);
    #1;
    ready_i = 1'b1;
    send(4'h8); send(4'h4); send(4'h2); send(4'h1);
    @(negedge clk);
    chk("mid_reset_frame_valid", {7'd0, valid_o}, 8'd1);
    chk("mid_reset_frame_c0", {4'd0, data_o}, 8'h08);
    @(posedge clk);
    #1;
    idle(6);
    chk("final_queue_empty", 8'(exp_q.size()), 8'd0);
    chk("final_no_partial", 8'(wr_n), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/transpose_pp.md
TRANSPOSE_PP -- requirements
Module: transpose_pp

Interface
REQ-001 SHALL have parameter N, default 32: matrix dimension, equal to both word width and words per frame; legal range 2..64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port data_i  input  N  input row word.
REQ-005 SHALL have port valid_i  input  1  data_i valid.
REQ-006 SHALL have port ready_o  output  1  block can accept a row this cycle.
REQ-007 SHALL have port data_o  output  N  transposed output word (column).
REQ-008 SHALL have port valid_o  output  1  data_o valid.
REQ-009 SHALL have port ready_i  input  1  downstream accepts data_o this cycle.
REQ-010 SHALL have port last_o  output  1  data_o is the final word (index N-1) of a frame; meaningful only with valid_o.

Function
REQ-011 SHALL define a frame as N consecutive accepted input words w0..w(N-1) and output it as N words c0..c(N-1), where c_j bit k = w_k bit j.
REQ-012 SHALL accept an input word on a cycle only when valid_i=1 and ready_o=1 (write handshake).
REQ-013 SHALL advance the output only when valid_o=1 and ready_i=1 (read handshake); data_o, last_o SHALL hold stable while valid_o=1 and ready_i=0.
REQ-014 SHALL hold two N x N bit banks (ping-pong), a write-bank select, a read-bank select, a write row counter, a read column counter (each $clog2(N) bits), and one full flag per bank.
REQ-015 SHALL store an accepted word into row wr_cnt of the write bank, then increment wr_cnt; on the N-th accepted word it SHALL wrap wr_cnt to 0, set that bank's full flag and toggle the write-bank select.
REQ-016 SHALL drive ready_o = NOT full flag of the current write bank, and 0 while rst=1.
REQ-017 SHALL drive valid_o = full flag of the current read bank, and 0 while rst=1.
REQ-018 SHALL drive data_o = column rd_cnt of the read bank when valid_o=1, else all zeros.
REQ-019 SHALL increment rd_cnt on each read handshake; on the handshake with rd_cnt=N-1 it SHALL wrap rd_cnt to 0, clear that bank's full flag and toggle the read-bank select.
REQ-020 SHALL drive last_o = valid_o AND (rd_cnt = N-1).
REQ-021 Latency: the N-th write handshake in cycle t SHALL yield valid_o=1 with c0 in cycle t+1 if the read bank was empty.
REQ-022 Throughput: with valid_i=1 and ready_i=1 continuously, SHALL accept one word and emit one word per cycle after the first frame; ready_o SHALL never drop.
REQ-023 Simultaneous events: a frame-completing write and a frame-completing read in the same cycle SHALL both take effect (different banks); full flags updated independently.
REQ-024 Both banks full: ready_o=0; input ignored regardless of valid_i until the read bank drains.
REQ-025 Frame order SHALL be preserved: frames emitted in acceptance order, no frame dropped or duplicated.
REQ-026 Bank contents SHALL not be cleared; only control state is reset.

Reset
REQ-027 On a rising clk edge with rst=1 SHALL set wr_cnt=0, rd_cnt=0, both full flags=0, both selects=0.
REQ-028 After reset SHALL present ready_o=1, valid_o=0, data_o=0, last_o=0.
REQ-029 Reset mid-frame SHALL discard any partial input frame and any unread/partially read output frame; next accepted word is w0 of a new frame.

Verification (N=4)
REQ-030 Identity: write 4'h1,4'h2,4'h4,4'h8 back-to-back, ready_i=1 -> outputs 4'h1,4'h2,4'h4,4'h8, valid_o starts cycle after 4th write, last_o with 4'h8.
REQ-031 Single row: write 4'hF,4'h0,4'h0,4'h0 -> outputs 4'h1,4'h1,4'h1,4'h1; write 4'h0,4'h0,4'h0,4'hF -> four 4'h8.
REQ-032 Backpressure: ready_i=0 with two frames written -> ready_o=0 after 8th write, 9th word not accepted, data_o holds c0 of frame 1; release ready_i -> frame 1 then frame 2 in order, ready_o returns to 1 after c3 of frame 1 read.
REQ-033 Streaming: 3 frames, valid_i=1, ready_i=1 every cycle -> ready_o stays 1, valid_o continuous from cycle 5 through 12, all 12 output words correct.
REQ-034 Random gaps: valid_i asserted ~70% of cycles, ready_i ~70% random -> scoreboard matches REQ-011 for 100 frames, no loss or reorder.
REQ-035 Reset mid-operation: rst=1 for one cycle after 2 words of frame 2 while frame 1 half-read -> next cycle ready_o=1, valid_o=0, data_o=0; following 4 writes form a fresh frame output correctly.
